prefix_adder_pipe: RTL and testbench
====================================

// Module: prefix_adder_pipe
// PURPOSE
//  Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor for the ALU datapath.
//  Generalises the fixed single prefix level:
//  - all clog2(WIDTH) prefix levels are generated;
//  - pipeline registers are placed at configurable level intervals;
//  - carry-in, ADD/SUB mode, and cout/overflow/zero flags are supported;
//  - valid/ready flow control lets it sit between issue and writeback.
// PARAMETERS
//  WIDTH      `LEN_DATA (32)  operand width, >=2, power of two not required
//  REG_EVERY  2               register after every REG_EVERY-th prefix level; 0 = none internal
//  LEVELS     clog2(WIDTH)    derived localparam, number of prefix levels
//  LATENCY    derived         2 + (REG_EVERY ? (LEVELS-1)/REG_EVERY : 0); 4 for defaults
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous reset, active high
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block accepts beat this cycle
//  op_sub     in   1      0: a+b+cin ; 1: a-b (b inverted, carry-in forced 1, cin ignored)
//  a, b       in   WIDTH  operands
//  cin        in   1      carry-in (ADD only)
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry out of MSB (SUB: 1 = no borrow)
//  ovf        out  1      signed overflow = carry into MSB ^ carry out of MSB
//  zero       out  1      sum == 0
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): all stage valid bits 0, out_valid=0, sum=0, cout=ovf=0, zero=0.
//    Data regs may clear or hold; valids are authoritative. In-flight beats discarded.
//  - Stage 0 registers b'=op_sub?~b:b, c0=op_sub|cin; computes bitwise g=a&b', p=a^b'.
//    cin folded at bit 0: G0 = g0 | (p0&c0).
//  - Level k (1..LEVELS), distance d=2^(k-1):
//    for i>=d: G[i]=G[i]|P[i]&G[i-d], P[i]=P[i]&P[i-d]; for i<d: pass through.
//  - Register after level k when REG_EVERY!=0, k%REG_EVERY==0, k<LEVELS.
//    Final stage computes sum[i]=p[i]^C[i] (C[0]=c0, C[i]=G[i-1]), cout=G[W-1], flags; all registered.
//  - Flow control: global advance adv = out_ready | ~out_valid; in_ready = adv.
//    All stages shift on adv; valid bit travels with data. No internal bubble collapse.
//  - Accept: in_valid & in_ready. Output handshake completes on out_valid & out_ready.
//    Outputs are held stable while out_valid & ~out_ready.
//  - Throughput 1 beat/cycle when out_ready=1; results in order; latency = LATENCY cycles accept->out_valid.
//  - Simultaneous accept and output handshake in the same cycle: both occur, no loss.
//  - rst overrides any handshake in the same cycle.
//  - Width wrap: sum is mod 2^WIDTH; carry beyond MSB only on cout.
// STRUCTURE
//  - main.def.v: LEN_DATA, plus new `define ADD_OP 1'b0 / SUB_OP 1'b1.
//    No other shared typedefs.
//  - Sub-module adder_prefix_level (params WIDTH, DIST): one combinational prefix level built from gp_cell.
//    Instantiated LEVELS times in a generate loop; pipeline registers and valid chain live in the top.
// TESTING (WIDTH=32, REG_EVERY=2, LATENCY=4 unless stated)
//  1. add a=FFFFFFFF b=00000001 cin=0
//     -> 4 cycles later sum=00000000 cout=1 ovf=0 zero=1.
//  2. sub a=80000000 b=00000001
//     -> sum=7FFFFFFF cout=1 ovf=1 zero=0.
//  3. add a=7FFFFFFF b=0 cin=1
//     -> sum=80000000 cout=0 ovf=1; with op_sub=1, cin=1 is ignored.
//  4. 8 back-to-back beats, out_ready=0 for 2 cycles mid-stream
//     -> in_ready=0 those cycles, outputs held, all 8 results in order, none duplicated.
//  5. rst pulsed for 1 cycle with 3 beats in flight
//     -> next cycle out_valid=0; none of the 3 ever emerge; next beat appears LATENCY later.
//  6. 10k random beats with random stalls, WIDTH in {8,32,64}, REG_EVERY in {0,1,2}
//     -> match behavioural a+b+cin model, LATENCY matches formula.

Source files
------------

// File: rtl/prefix_adder_pipe_pkg.sv
// Shared definitions for the pipelined parallel-prefix adder.
//   LEN_DATA        default datapath width
//   ADD_OP/SUB_OP   encodings of the op_sub input
//   gp_t / gp_cell  generate/propagate pair and the prefix combine operator
package prefix_adder_pipe_pkg;

    localparam int   LEN_DATA = 32;
    localparam logic ADD_OP   = 1'b0;
    localparam logic SUB_OP   = 1'b1;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Combine a higher-order (G,P) span with the adjacent lower-order span.
    function automatic gp_t gp_cell(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/prefix_adder_pipe_level.sv
// One combinational Kogge-Stone prefix level.
// Bits at or above DIST combine with the span DIST positions below;
// lower bits pass through unchanged.
//   g_in, p_in    group generate/propagate entering the level
//   g_out, p_out  group generate/propagate leaving the level
module prefix_adder_pipe_level
    import prefix_adder_pipe_pkg::*;
#(
    parameter int WIDTH = LEN_DATA,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] g_in,
    input  logic [WIDTH-1:0] p_in,
    output logic [WIDTH-1:0] g_out,
    output logic [WIDTH-1:0] p_out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= DIST) begin : g_cell
            gp_t hi;
            gp_t lo;
            gp_t res;
            assign hi       = {g_in[i], p_in[i]};
            assign lo       = {g_in[i-DIST], p_in[i-DIST]};
            assign res      = gp_cell(hi, lo);
            assign g_out[i] = res.g;
            assign p_out[i] = res.p;
        end else begin : g_pass
            assign g_out[i] = g_in[i];
            assign p_out[i] = p_in[i];
        end
    end

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
// All clog2(WIDTH) prefix levels are built; a register stage follows every
// REG_EVERY-th level (none internal when REG_EVERY == 0). Latency from the
// accepting cycle to out_valid is 2 + (REG_EVERY ? (LEVELS-1)/REG_EVERY : 0).
//   clk, rst              clock and synchronous active-high reset
//   in_valid, in_ready    operand handshake
//   op_sub                0: a+b+cin, 1: a-b (cin ignored)
//   a, b, cin             operands and carry-in
//   out_valid, out_ready  result handshake
//   sum, cout, ovf, zero  result, carry out of MSB, signed overflow, sum==0
module prefix_adder_pipe
    import prefix_adder_pipe_pkg::*;
#(
    parameter int WIDTH     = LEN_DATA,
    parameter int REG_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int LEVELS = $clog2(WIDTH);
    // Safe divisor so the modulo below stays legal when REG_EVERY is 0.
    localparam int RE_DIV = (REG_EVERY != 0) ? REG_EVERY : 1;

    // Whole pipe moves as one; a stalled output freezes every stage.
    logic adv;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    // ---- Stage 0: operand capture (subtraction folded into b and c0) ----
    logic [WIDTH-1:0] a_p0, bx_p0;
    logic             c0_p0, vld_p0;

    always_ff @(posedge clk) begin
        if (rst)      vld_p0 <= 1'b0;
        else if (adv) vld_p0 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            a_p0  <= a;
            bx_p0 <= (op_sub == SUB_OP) ? ~b : b;
            c0_p0 <= (op_sub == ADD_OP) ? cin : 1'b1;
        end
    end

    // Element k holds what enters prefix level k; LEVELS+1 feeds the sum stage.
    logic [WIDTH-1:0] lg [1:LEVELS+1];
    logic [WIDTH-1:0] lp [1:LEVELS+1];
    logic [WIDTH-1:0] pb [1:LEVELS+1];
    logic             c0s [1:LEVELS+1];
    logic             vs  [1:LEVELS+1];

    // Carry-in enters as extra generate at bit 0, so every G[i] includes it.
    assign lg[1]  = (a_p0 & bx_p0) |
                    {{(WIDTH-1){1'b0}}, (a_p0[0] ^ bx_p0[0]) & c0_p0};
    assign lp[1]  = a_p0 ^ bx_p0;
    assign pb[1]  = a_p0 ^ bx_p0;
    assign c0s[1] = c0_p0;
    assign vs[1]  = vld_p0;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        logic [WIDTH-1:0] g_k, p_k;

        prefix_adder_pipe_level #(
            .WIDTH(WIDTH),
            .DIST (1 << (k - 1))
        ) u_level (
            .g_in (lg[k]),
            .p_in (lp[k]),
            .g_out(g_k),
            .p_out(p_k)
        );

        if ((REG_EVERY != 0) && (k % RE_DIV == 0) && (k < LEVELS)) begin : g_reg
            // ---- Stage boundary after prefix level k ----
            logic [WIDTH-1:0] g_pk, p_pk, pb_pk;
            logic             c0_pk, vld_pk;

            always_ff @(posedge clk) begin
                if (rst)      vld_pk <= 1'b0;
                else if (adv) vld_pk <= vs[k];
            end

            always_ff @(posedge clk) begin
                if (adv) begin
                    g_pk  <= g_k;
                    p_pk  <= p_k;
                    pb_pk <= pb[k];
                    c0_pk <= c0s[k];
                end
            end

            assign lg[k+1]  = g_pk;
            assign lp[k+1]  = p_pk;
            assign pb[k+1]  = pb_pk;
            assign c0s[k+1] = c0_pk;
            assign vs[k+1]  = vld_pk;
        end else begin : g_comb
            assign lg[k+1]  = g_k;
            assign lp[k+1]  = p_k;
            assign pb[k+1]  = pb[k];
            assign c0s[k+1] = c0s[k];
            assign vs[k+1]  = vs[k];
        end
    end

    // Carry into bit i is the group generate of bits [i-1:0].
    logic [WIDTH-1:0] gf, carry, sum_d;
    assign gf    = lg[LEVELS+1];
    assign carry = {gf[WIDTH-2:0], c0s[LEVELS+1]};
    assign sum_d = pb[LEVELS+1] ^ carry;

    // ---- Output stage: sum and flags ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (adv) begin
            out_valid <= vs[LEVELS+1];
            sum       <= sum_d;
            cout      <= gf[WIDTH-1];
            ovf       <= gf[WIDTH-1] ^ gf[WIDTH-2];
            zero      <= (sum_d == '0);
        end
    end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Bench for prefix_adder_pipe: three configurations share the stimulus,
// each with its own scoreboard; directed cases target the 32-bit instance.
module tb_prefix_adder_pipe;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int unsigned stamp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        op_sub = 1'b0;
    logic        cin = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] a = '0;
    logic [63:0] b = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference: plain integer add at width w, signed overflow from operand/result signs.
    function automatic exp_t model(input int w, input logic sub, input logic [63:0] av,
                                   input logic [63:0] bv, input logic c);
        exp_t        e;
        logic [63:0] m, aa, bb;
        logic [64:0] full;
        logic        ci;
        m      = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        aa     = av & m;
        bb     = (sub ? ~bv : bv) & m;
        ci     = sub ? 1'b1 : c;
        full   = {1'b0, aa} + {1'b0, bb} + {64'd0, ci};
        e.sum  = full[63:0] & m;
        e.cout = full[w];
        e.ovf  = (aa[w-1] == bb[w-1]) && (e.sum[w-1] != aa[w-1]);
        e.zero = (e.sum == 64'd0);
        e.stamp = 0;
        return e;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int W   = (gi == 0) ? 32 : ((gi == 1) ? 8 : 64);
        localparam int RE  = (gi == 0) ? 2  : ((gi == 1) ? 0 : 1);
        localparam int LAT = (gi == 0) ? 4  : ((gi == 1) ? 2 : 7);

        logic [W-1:0] s_w;
        logic         rdy_w, vld_w, co_w, of_w, z_w;
        exp_t         q[$];
        int           pend = 0;
        int           outs = 0;

        prefix_adder_pipe #(.WIDTH(W), .REG_EVERY(RE)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (rdy_w),
            .op_sub   (op_sub),
            .a        (a[W-1:0]),
            .b        (b[W-1:0]),
            .cin      (cin),
            .out_valid(vld_w),
            .out_ready(out_ready),
            .sum      (s_w),
            .cout     (co_w),
            .ovf      (of_w),
            .zero     (z_w)
        );

        // advc counts clock edges on which the pipe advanced; a beat must land
        // after exactly LAT-1 advancing edges following its acceptance.
        initial begin : mon
            exp_t        e;
            int unsigned advc;
            bit          held;
            advc = 0;
            held = 1'b0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    q.delete();
                    held = 1'b0;
                end else begin
                    if (vld_w && !held) begin
                        chk($sformatf("occupied%0d", gi), 64'(q.size() > 0), 64'd1);
                        if (q.size() > 0)
                            chk($sformatf("latency%0d", gi), 64'(advc), 64'(q[0].stamp + LAT - 1));
                    end
                    if (vld_w && out_ready && q.size() > 0) begin
                        e = q.pop_front();
                        chk($sformatf("sum%0d", gi),  64'(s_w),  e.sum);
                        chk($sformatf("cout%0d", gi), 64'(co_w), 64'(e.cout));
                        chk($sformatf("ovf%0d", gi),  64'(of_w), 64'(e.ovf));
                        chk($sformatf("zero%0d", gi), 64'(z_w),  64'(e.zero));
                        outs++;
                    end
                    held = vld_w && !out_ready;
                    if (in_valid && rdy_w) begin
                        e = model(W, op_sub, a, b, cin);
                        e.stamp = advc + 1;
                        q.push_back(e);
                    end
                    if (rdy_w) advc++;
                end
                pend = q.size();
            end
        end
    end

    // Send one beat into an idle pipe and check the 32-bit result against constants.
    task automatic send_check(input string tag, input logic sub, input logic [63:0] av,
                              input logic [63:0] bv, input logic c, input logic [63:0] es,
                              input logic ec, input logic eo, input logic ez);
        int n;
        @(posedge clk); #1;
        op_sub = sub; a = av; b = bv; cin = c; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_rdy"}, 64'(g_dut[0].rdy_w), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!g_dut[0].vld_w && n < 20);
        chk({tag, "_lat"},  64'(n), 64'd4);
        chk({tag, "_sum"},  64'(g_dut[0].s_w),  es);
        chk({tag, "_cout"}, 64'(g_dut[0].co_w), 64'(ec));
        chk({tag, "_ovf"},  64'(g_dut[0].of_w), 64'(eo));
        chk({tag, "_zero"}, 64'(g_dut[0].z_w),  64'(ez));
    endtask

    function automatic logic [63:0] pick(input int sel);
        case (sel)
            0:       return '1;
            1:       return '0;
            2:       return 64'h8000_0000_8000_0080;
            3:       return 64'h7FFF_FFFF_7FFF_FF7F;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin : main
        logic [63:0] held_sum;
        int          acc, cyc, base;
        bit          new_beat;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld",  64'(g_dut[0].vld_w), 64'd0);
        chk("rst_sum",  64'(g_dut[0].s_w),   64'd0);
        chk("rst_cout", 64'(g_dut[0].co_w),  64'd0);
        chk("rst_ovf",  64'(g_dut[0].of_w),  64'd0);
        chk("rst_zero", 64'(g_dut[0].z_w),   64'd0);
        chk("rst_vld1", 64'(g_dut[1].vld_w), 64'd0);
        chk("rst_vld2", 64'(g_dut[2].vld_w), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed arithmetic cases
        send_check("t1",    1'b0, 64'hFFFF_FFFF, 64'h1, 1'b0, 64'h0,         1'b1, 1'b0, 1'b1);
        send_check("t2",    1'b1, 64'h8000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        send_check("t3",    1'b0, 64'h7FFF_FFFF, 64'h0, 1'b1, 64'h8000_0000, 1'b0, 1'b1, 1'b0);
        send_check("t3sub", 1'b1, 64'h7FFF_FFFF, 64'h0, 1'b1, 64'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
        send_check("wrap",  1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        send_check("self",  1'b1, 64'h1234_5678, 64'h1234_5678, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);

        // Back-to-back beats with a two-cycle output stall
        base = g_dut[0].outs;
        acc = 0;
        cyc = 0;
        new_beat = 1'b1;
        @(posedge clk); #1;
        while (acc < 8 && cyc < 40) begin
            if (new_beat) begin
                op_sub = acc[0];
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                cin = 1'($urandom_range(0, 1));
            end
            in_valid = 1'b1;
            out_ready = (cyc != 5 && cyc != 6);
            @(negedge clk);
            if (cyc == 5) begin
                chk("t4_stall_rdy5", 64'(g_dut[0].rdy_w), 64'd0);
                held_sum = 64'(g_dut[0].s_w);
            end
            if (cyc == 6) begin
                chk("t4_stall_rdy6", 64'(g_dut[0].rdy_w), 64'd0);
                chk("t4_hold", 64'(g_dut[0].s_w), held_sum);
            end
            new_beat = g_dut[0].rdy_w;
            if (g_dut[0].rdy_w) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("t4_count", 64'(g_dut[0].outs - base), 64'd8);
        chk("t4_empty", 64'(g_dut[0].pend), 64'd0);

        // Reset with three beats in flight
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; op_sub = 1'b0; cin = 1'b0;
            a = 64'(i + 5); b = 64'h100;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_vld", 64'(g_dut[0].vld_w), 64'd0);
        chk("t5_sum", 64'(g_dut[0].s_w),   64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t5_quiet", 64'(g_dut[0].vld_w), 64'd0);
        end
        send_check("t5_next", 1'b0, 64'h10, 64'h20, 1'b1, 64'h31, 1'b0, 1'b0, 1'b0);

        // Random traffic with random stalls on all three configurations
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op_sub    = 1'($urandom_range(0, 1));
            cin       = 1'($urandom_range(0, 1));
            a         = pick($urandom_range(0, 9));
            b         = pick($urandom_range(0, 9));
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("t6_empty0", 64'(g_dut[0].pend), 64'd0);
        chk("t6_empty1", 64'(g_dut[1].pend), 64'd0);
        chk("t6_empty2", 64'(g_dut[2].pend), 64'd0);
        chk("t6_flow0",  64'(g_dut[0].outs > 3000), 64'd1);
        chk("t6_flow2",  64'(g_dut[2].outs > 3000), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
